hazard_ctrl_unit: RTL and testbench
===================================

// Module: hazard_ctrl_unit
// PURPOSE
//  Next-gen hazard controller for the 5-stage pipeline: load-use stall (multi-cycle, rt-use aware),
//  I/D-cache miss wait, branch/jump flush at a configurable resolve stage, sticky halt, plus EX operand
//  forwarding selects. Sits beside the datapath and drives all latch enables/flushes and pc_freeze.
// PARAMETERS
//  REG_W      5   register index width
//  LU_CYCLES  1   bubbles inserted per load-use hazard (1..7)
//  BR_STAGE   3   branch resolve stage: 2=EX (flush ifid,idex), 3=MEM (flush ifid,idex,exmem)
//  CNT_W      16  perf counter width (HAZARD_PERF_CNT_EN only)
// PORTS
//  CLK          in   1      clock, rising edge
//  nRST         in   1      asynchronous active-low reset
//  ifid_instr   in   32     instruction in IF/ID
//  idex_rs/rt   in   REG_W  EX source regs;  idex_memRd, idex_regWr in 1: EX op is load / writes reg
//  exmem_wsel   in   REG_W  MEM dest;  exmem_regWr, exmem_dREN, exmem_dWEN in 1
//  memwb_wsel   in   REG_W  WB dest;   memwb_regWr, memwb_halt in 1
//  ihit, dhit   in   1      cache hits;  pcsrc in 2: nonzero = redirect taken (at BR_STAGE)
//  {ifid,idex,exmem,memwb}_flush, _freeze  out 1 each;  pc_freeze out 1
//  fwd_a, fwd_b out  2      00 regfile, 10 from EX/MEM, 01 from MEM/WB
//  hz_state     out  2      current FSM state (debug)
//  stall_cnt, flush_cnt out CNT_W  (HAZARD_PERF_CNT_EN only)
// BEHAVIOUR
//  - nRST=0: state=RUN, lu_cnt=0, counters=0; all flush/freeze/fwd outputs forced 0 while in reset.
//  - Outputs combinational from state+inputs (Mealy); state/lu_cnt/counters update on CLK posedge.
//  - FSM (hz_state_t): RUN=0, LU_STALL=1, MEM_WAIT=2, HALTED=3.
//  - uses_rt = opcode in {RTYPE 6'h00, BEQ 6'h04, BNE 6'h05, SW 6'h2B}.
//  - lu_hit = idex_memRd & idex_regWr & idex_rt!=0 & (idex_rt==ifid_rs | uses_rt & idex_rt==ifid_rt).
//  - dwait = (exmem_dREN|exmem_dWEN) & !dhit.
//  - Priority per cycle: HALTED > dwait > branch > lu_hit > !ihit.
//  - HALTED: all *_freeze=1, pc_freeze=1, no flush; entered the cycle after memwb_halt=1; exit only by reset.
//  - dwait (any state but HALTED): pc/ifid/idex/exmem freeze=1, memwb_flush=1; state->MEM_WAIT; stays while
//    dwait; on dhit returns to RUN (or resumes LU_STALL with lu_cnt preserved).
//  - Branch (pcsrc!=0, no dwait): ifid_flush, idex_flush, plus exmem_flush iff BR_STAGE==3; overrides and
//    cancels any LU_STALL (state->RUN, lu_cnt=0) since the dependent instr is squashed.
//  - lu_hit in RUN: pc_freeze, ifid_freeze, idex_flush; lu_cnt=LU_CYCLES-1; state->LU_STALL if LU_CYCLES>1.
//    LU_STALL: same outputs, lu_cnt decrements; at lu_cnt==0 -> RUN. Total bubbles = LU_CYCLES exactly.
//  - !ihit alone: pc_freeze=1, ifid_flush=1 (bubble into ID); no state change.
//  - Forwarding (independent of FSM, forced 00 in HALTED): fwd_a=10 if exmem_regWr & exmem_wsel!=0 &
//    exmem_wsel==idex_rs; else 01 if memwb_regWr & memwb_wsel!=0 & memwb_wsel==idex_rs; else 00. fwd_b same on idex_rt.
//  - Never assert flush and freeze on the same latch; freeze wins (flush deferred while frozen).
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: stall_cnt += 1 each cycle pc_freeze=1 (excluding HALTED); flush_cnt += 1 each
//   branch flush; both saturate at all-ones. Undefined: ports absent, no counter flops.
// STRUCTURE
//  cpu_types_pkg: hz_state_t, fwd_sel_t (FWD_RF/FWD_EXMEM/FWD_MEMWB), opcode constants used by uses_rt.
//  Sub-module forwarding_unit (combinational fwd_a/fwd_b); FSM, lu_cnt, counters in hazard_ctrl_unit.
// TESTING
//  1. lw $2 in EX, add $3,$2,$4 in ID, LU_CYCLES=2 -> pc/ifid_freeze+idex_flush 2 cycles, then RUN.
//  2. lw $2 in EX, addi $2,$5,1 in ID (rt is dest) -> no stall; idex_rt=0 load -> no stall.
//  3. exmem_dREN=1, dhit=0 for 3 cycles -> MEM_WAIT, freezes+memwb_flush 3 cycles; dhit=1 -> RUN.
//  4. pcsrc=1, BR_STAGE=3 -> ifid/idex/exmem_flush=1 one cycle; BR_STAGE=2 -> exmem_flush=0.
//  5. branch during LU_STALL -> flushes, lu_cnt=0, RUN next; branch during dwait -> flush on dhit cycle.
//  6. exmem_wsel=memwb_wsel=idex_rs=7, both regWr -> fwd_a=10; memwb_halt=1 -> HALTED, all freezes;
//     nRST pulse mid-stall -> outputs 0, RUN; PERF_EN: counters match cycle counts.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: hazard FSM states, forwarding selects, opcode constants.
package cpu_types_pkg;

  localparam int unsigned LU_CNT_W = 3;
  localparam int unsigned OP_W     = 6;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_LU_STALL = 2'd1,
    HZ_MEM_WAIT = 2'd2,
    HZ_HALTED   = 2'd3
  } hz_state_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  // True when the instruction reads its rt field as a source operand.
  function automatic logic op_uses_rt(input logic [OP_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/forwarding_unit.sv
// EX-stage operand forwarding selects; EX/MEM result takes precedence over MEM/WB.
module forwarding_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  logic [REG_W-1:0] idex_rs,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] exmem_wsel,
  input  logic             exmem_regWr,
  input  logic [REG_W-1:0] memwb_wsel,
  input  logic             memwb_regWr,
  output fwd_sel_t         fwd_a,
  output fwd_sel_t         fwd_b
);

  logic ex_valid;
  logic wb_valid;

  // Register 0 is hardwired, so it never forwards.
  assign ex_valid = exmem_regWr && (exmem_wsel != '0);
  assign wb_valid = memwb_regWr && (memwb_wsel != '0);

  // Pick the youngest producer for each EX source operand.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (ex_valid && (exmem_wsel == idex_rs))      fwd_a = FWD_EXMEM;
    else if (wb_valid && (memwb_wsel == idex_rs)) fwd_a = FWD_MEMWB;
    if (ex_valid && (exmem_wsel == idex_rt))      fwd_b = FWD_EXMEM;
    else if (wb_valid && (memwb_wsel == idex_rt)) fwd_b = FWD_MEMWB;
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stall, cache-miss wait, branch flush, halt, forwarding.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush performance counters.
module hazard_ctrl_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned REG_W     = 5,
  parameter int unsigned LU_CYCLES = 1,
  parameter int unsigned BR_STAGE  = 3
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W     = 16
`endif
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [31:0]      ifid_instr,
  input  logic [REG_W-1:0] idex_rs,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             idex_memRd,
  input  logic             idex_regWr,
  input  logic [REG_W-1:0] exmem_wsel,
  input  logic             exmem_regWr,
  input  logic             exmem_dREN,
  input  logic             exmem_dWEN,
  input  logic [REG_W-1:0] memwb_wsel,
  input  logic             memwb_regWr,
  input  logic             memwb_halt,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [1:0]       pcsrc,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             ifid_freeze,
  output logic             idex_freeze,
  output logic             exmem_freeze,
  output logic             memwb_freeze,
  output logic             pc_freeze,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       hz_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  hz_state_t             state_q, state_d;
  logic [LU_CNT_W-1:0]   lu_cnt_q, lu_cnt_d;
  logic [OP_W-1:0]       ifid_op;
  logic [REG_W-1:0]      ifid_rs, ifid_rt;
  logic                  unused_instr;
  logic                  lu_hit, dwait, br_taken, lu_active;
  logic                  pc_frz, ifid_frz, idex_frz, exmem_frz, memwb_frz;
  logic                  ifid_fl, idex_fl, exmem_fl, memwb_fl;
  fwd_sel_t              fwd_a_raw, fwd_b_raw;

  assign ifid_op      = ifid_instr[31:26];
  assign ifid_rs      = REG_W'(ifid_instr[25:21]);
  assign ifid_rt      = REG_W'(ifid_instr[20:16]);
  assign unused_instr = ^ifid_instr[15:0];

  // Hazard detection terms.
  assign lu_hit   = idex_memRd && idex_regWr && (idex_rt != '0) &&
                    ((idex_rt == ifid_rs) || (op_uses_rt(ifid_op) && (idex_rt == ifid_rt)));
  assign dwait    = (exmem_dREN || exmem_dWEN) && !dhit;
  assign br_taken = (pcsrc != 2'b00);
  // A load-use stall interrupted by a cache miss resumes once the miss clears.
  assign lu_active = (state_q == HZ_LU_STALL) ||
                     ((state_q == HZ_MEM_WAIT) && (lu_cnt_q != '0));

  // State and bubble counter register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= HZ_RUN;
      lu_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  // Next state and raw latch controls, in priority order halt > dwait > branch > load-use > imiss.
  always_comb begin
    state_d   = state_q;
    lu_cnt_d  = lu_cnt_q;
    pc_frz    = 1'b0;
    ifid_frz  = 1'b0;
    idex_frz  = 1'b0;
    exmem_frz = 1'b0;
    memwb_frz = 1'b0;
    ifid_fl   = 1'b0;
    idex_fl   = 1'b0;
    exmem_fl  = 1'b0;
    memwb_fl  = 1'b0;
    if (state_q == HZ_HALTED) begin
      pc_frz    = 1'b1;
      ifid_frz  = 1'b1;
      idex_frz  = 1'b1;
      exmem_frz = 1'b1;
      memwb_frz = 1'b1;
    end else if (dwait) begin
      pc_frz    = 1'b1;
      ifid_frz  = 1'b1;
      idex_frz  = 1'b1;
      exmem_frz = 1'b1;
      memwb_fl  = 1'b1;
      state_d   = HZ_MEM_WAIT;
    end else if (br_taken) begin
      ifid_fl  = 1'b1;
      idex_fl  = 1'b1;
      exmem_fl = (BR_STAGE == 3);
      state_d  = HZ_RUN;
      lu_cnt_d = '0;
    end else if (lu_active) begin
      pc_frz   = 1'b1;
      ifid_frz = 1'b1;
      idex_fl  = 1'b1;
      lu_cnt_d = lu_cnt_q - LU_CNT_W'(1);
      state_d  = (lu_cnt_q == LU_CNT_W'(1)) ? HZ_RUN : HZ_LU_STALL;
    end else if (lu_hit) begin
      pc_frz   = 1'b1;
      ifid_frz = 1'b1;
      idex_fl  = 1'b1;
      lu_cnt_d = LU_CNT_W'(LU_CYCLES - 1);
      state_d  = (LU_CYCLES > 1) ? HZ_LU_STALL : HZ_RUN;
    end else begin
      state_d = HZ_RUN;
      if (!ihit) begin
        pc_frz  = 1'b1;
        ifid_fl = 1'b1;
      end
    end
    if (memwb_halt) state_d = HZ_HALTED;
  end

  forwarding_unit #(.REG_W(REG_W)) u_fwd (
    .idex_rs     (idex_rs),
    .idex_rt     (idex_rt),
    .exmem_wsel  (exmem_wsel),
    .exmem_regWr (exmem_regWr),
    .memwb_wsel  (memwb_wsel),
    .memwb_regWr (memwb_regWr),
    .fwd_a       (fwd_a_raw),
    .fwd_b       (fwd_b_raw)
  );

  // Outputs held low in reset; a frozen latch never sees its flush.
  assign pc_freeze    = nRST && pc_frz;
  assign ifid_freeze  = nRST && ifid_frz;
  assign idex_freeze  = nRST && idex_frz;
  assign exmem_freeze = nRST && exmem_frz;
  assign memwb_freeze = nRST && memwb_frz;
  assign ifid_flush   = nRST && ifid_fl  && !ifid_frz;
  assign idex_flush   = nRST && idex_fl  && !idex_frz;
  assign exmem_flush  = nRST && exmem_fl && !exmem_frz;
  assign memwb_flush  = nRST && memwb_fl && !memwb_frz;
  assign fwd_a        = (nRST && (state_q != HZ_HALTED)) ? fwd_a_raw : FWD_RF;
  assign fwd_b        = (nRST && (state_q != HZ_HALTED)) ? fwd_b_raw : FWD_RF;
  assign hz_state     = state_q;

`ifdef HAZARD_PERF_CNT_EN
  // Saturating counts of stalled fetch cycles and branch flushes.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_frz && (state_q != HZ_HALTED) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((state_q != HZ_HALTED) && !dwait && br_taken && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: u_dut (LU_CYCLES=2, BR_STAGE=3), u_dut2 (LU_CYCLES=3, BR_STAGE=2).
module tb_hazard_ctrl_unit;

  localparam logic [1:0] R = 2'd0, L = 2'd1, M = 2'd2, H = 2'd3;
  localparam logic [4:0] FZ_NONE = 5'b00000, FZ_LU = 5'b11000, FZ_DW = 5'b11110,
                         FZ_H = 5'b11111, FZ_IM = 5'b10000;
  localparam logic [3:0] FL_NONE = 4'b0000, FL_LU = 4'b0100, FL_DW = 4'b0001,
                         FL_BR = 4'b1110, FL_IM = 4'b1000;
  localparam logic [31:0] I_ADD_RS = {6'h00, 5'd2, 5'd4, 5'd3, 5'd0, 6'h20};
  localparam logic [31:0] I_ADD_RT = {6'h00, 5'd4, 5'd2, 5'd3, 5'd0, 6'h20};
  localparam logic [31:0] I_ADDI   = {6'h08, 5'd5, 5'd2, 16'd1};
  localparam logic [31:0] I_ADD_Z  = {6'h00, 5'd0, 5'd4, 5'd3, 5'd0, 6'h20};

  typedef struct packed {
    logic rst; logic [31:0] instr; logic [4:0] rs, rt; logic memrd, regwr;
    logic [4:0] ex_wsel; logic ex_wr, dren, dwen; logic [4:0] wb_wsel;
    logic wb_wr, halt, ihit, dhit; logic [1:0] pcsrc;
  } stim_t;

  typedef struct packed {
    logic [1:0] st; logic [4:0] fz; logic [3:0] fl; logic [1:0] fa, fb;
    logic [1:0] st2; logic pcf2;
  } exp_t;

  logic CLK, nRST;
  logic [31:0] ifid_instr;
  logic [4:0] idex_rs, idex_rt, exmem_wsel, memwb_wsel;
  logic idex_memRd, idex_regWr, exmem_regWr, exmem_dREN, exmem_dWEN;
  logic memwb_regWr, memwb_halt, ihit, dhit;
  logic [1:0] pcsrc;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic ifid_freeze, idex_freeze, exmem_freeze, memwb_freeze, pc_freeze;
  logic [1:0] fwd_a, fwd_b, hz_state;
  logic d2_ifid_flush, d2_idex_flush, d2_exmem_flush, d2_memwb_flush;
  logic d2_ifid_freeze, d2_idex_freeze, d2_exmem_freeze, d2_memwb_freeze, d2_pc_freeze;
  logic [1:0] d2_fwd_a, d2_fwd_b, d2_hz_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt, d2_stall_cnt, d2_flush_cnt;
  int unsigned sw_stall, sw_flush;
`endif

  int unsigned err_cnt = 0;
  int unsigned chk_cnt = 0;
  int unsigned step_n = 0;
  exp_t sb_q[$];
  exp_t e;
  stim_t s;

  hazard_ctrl_unit #(.REG_W(5), .LU_CYCLES(2), .BR_STAGE(3)) u_dut (
    .CLK(CLK), .nRST(nRST), .ifid_instr(ifid_instr), .idex_rs(idex_rs), .idex_rt(idex_rt),
    .idex_memRd(idex_memRd), .idex_regWr(idex_regWr), .exmem_wsel(exmem_wsel),
    .exmem_regWr(exmem_regWr), .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
    .memwb_wsel(memwb_wsel), .memwb_regWr(memwb_regWr), .memwb_halt(memwb_halt),
    .ihit(ihit), .dhit(dhit), .pcsrc(pcsrc),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .memwb_flush(memwb_flush), .ifid_freeze(ifid_freeze), .idex_freeze(idex_freeze),
    .exmem_freeze(exmem_freeze), .memwb_freeze(memwb_freeze), .pc_freeze(pc_freeze),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .hz_state(hz_state)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  hazard_ctrl_unit #(.REG_W(5), .LU_CYCLES(3), .BR_STAGE(2)) u_dut2 (
    .CLK(CLK), .nRST(nRST), .ifid_instr(ifid_instr), .idex_rs(idex_rs), .idex_rt(idex_rt),
    .idex_memRd(idex_memRd), .idex_regWr(idex_regWr), .exmem_wsel(exmem_wsel),
    .exmem_regWr(exmem_regWr), .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
    .memwb_wsel(memwb_wsel), .memwb_regWr(memwb_regWr), .memwb_halt(memwb_halt),
    .ihit(ihit), .dhit(dhit), .pcsrc(pcsrc),
    .ifid_flush(d2_ifid_flush), .idex_flush(d2_idex_flush), .exmem_flush(d2_exmem_flush),
    .memwb_flush(d2_memwb_flush), .ifid_freeze(d2_ifid_freeze), .idex_freeze(d2_idex_freeze),
    .exmem_freeze(d2_exmem_freeze), .memwb_freeze(d2_memwb_freeze), .pc_freeze(d2_pc_freeze),
    .fwd_a(d2_fwd_a), .fwd_b(d2_fwd_b), .hz_state(d2_hz_state)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(d2_stall_cnt), .flush_cnt(d2_flush_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    chk_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic stim_t idle();
    stim_t t;
    t = '0;
    t.rst = 1'b1; t.ihit = 1'b1; t.dhit = 1'b1;
    return t;
  endfunction

  // Load in EX writing $2, with the given instruction in ID.
  function automatic stim_t lw2(input logic [31:0] instr);
    stim_t t;
    t = idle();
    t.memrd = 1'b1; t.regwr = 1'b1; t.rt = 5'd2; t.rs = 5'd1; t.instr = instr;
    return t;
  endfunction

  function automatic exp_t ex(input logic [1:0] st, input logic [4:0] fz, input logic [3:0] fl,
                              input logic [1:0] fa, input logic [1:0] fb,
                              input logic [1:0] st2, input logic pcf2);
    exp_t t;
    t.st = st; t.fz = fz; t.fl = fl; t.fa = fa; t.fb = fb; t.st2 = st2; t.pcf2 = pcf2;
    return t;
  endfunction

  task automatic step(input stim_t t, input exp_t x);
    @(posedge CLK);
    #1;
    nRST = t.rst; ifid_instr = t.instr; idex_rs = t.rs; idex_rt = t.rt;
    idex_memRd = t.memrd; idex_regWr = t.regwr; exmem_wsel = t.ex_wsel;
    exmem_regWr = t.ex_wr; exmem_dREN = t.dren; exmem_dWEN = t.dwen;
    memwb_wsel = t.wb_wsel; memwb_regWr = t.wb_wr; memwb_halt = t.halt;
    ihit = t.ihit; dhit = t.dhit; pcsrc = t.pcsrc;
    sb_q.push_back(x);
  endtask

  // Pop the expectation for this cycle and compare away from the clock edge.
  always @(negedge CLK) begin
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk($sformatf("s%0d_state", step_n), 32'(hz_state), 32'(e.st));
      chk($sformatf("s%0d_freeze", step_n),
          32'({pc_freeze, ifid_freeze, idex_freeze, exmem_freeze, memwb_freeze}), 32'(e.fz));
      chk($sformatf("s%0d_flush", step_n),
          32'({ifid_flush, idex_flush, exmem_flush, memwb_flush}), 32'(e.fl));
      chk($sformatf("s%0d_fwd_a", step_n), 32'(fwd_a), 32'(e.fa));
      chk($sformatf("s%0d_fwd_b", step_n), 32'(fwd_b), 32'(e.fb));
      chk($sformatf("s%0d_d2_state", step_n), 32'(d2_hz_state), 32'(e.st2));
      chk($sformatf("s%0d_d2_pc_freeze", step_n), 32'(d2_pc_freeze), 32'(e.pcf2));
      chk($sformatf("s%0d_d2_exmem_flush", step_n), 32'(d2_exmem_flush), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
      if (!nRST) begin
        sw_stall = 0;
        sw_flush = 0;
      end else begin
        chk($sformatf("s%0d_stall_cnt", step_n), 32'(stall_cnt), sw_stall);
        chk($sformatf("s%0d_flush_cnt", step_n), 32'(flush_cnt), sw_flush);
        if (e.fz[4] && (e.st != H)) sw_stall++;
        if (e.fl[1]) sw_flush++;
      end
`endif
      step_n++;
    end
  end

  initial begin
    nRST = 1'b0; ifid_instr = '0; idex_rs = '0; idex_rt = '0; idex_memRd = 1'b0;
    idex_regWr = 1'b0; exmem_wsel = '0; exmem_regWr = 1'b0; exmem_dREN = 1'b0;
    exmem_dWEN = 1'b0; memwb_wsel = '0; memwb_regWr = 1'b0; memwb_halt = 1'b0;
    ihit = 1'b1; dhit = 1'b1; pcsrc = 2'b00;

    // Reset holds every control low despite active hazard inputs.
    s = idle(); s.rst = 1'b0; s.pcsrc = 2'b01; s.ihit = 1'b0; s.rs = 5'd7;
    s.ex_wsel = 5'd7; s.ex_wr = 1'b1; s.dren = 1'b1; s.dhit = 1'b0;
    step(s, ex(R, FZ_NONE, FL_NONE, 2'b00, 2'b00, R, 1'b0));
    step(idle(), ex(R, FZ_NONE, FL_NONE, 2'b00, 2'b00, R, 1'b0));
    s = idle(); s.ihit = 1'b0;
    step(s, ex(R, FZ_IM, FL_IM, 2'b00, 2'b00, R, 1'b1));

    // Load-use on rs: 2 bubbles (u_dut), 3 bubbles (u_dut2).
    step(lw2(I_ADD_RS), ex(R, FZ_LU, FL_LU, 2'b00, 2'b00, R, 1'b1));
    s = idle(); s.instr = I_ADD_RS;
    step(s, ex(L, FZ_LU, FL_LU, 2'b00, 2'b00, L, 1'b1));
    step(s, ex(R, FZ_NONE, FL_NONE, 2'b00, 2'b00, L, 1'b1));
    step(s, ex(R, FZ_NONE, FL_NONE, 2'b00, 2'b00, R, 1'b0));

    // Load-use on rt, then a branch cancels the remaining bubbles.
    step(lw2(I_ADD_RT), ex(R, FZ_LU, FL_LU, 2'b00, 2'b00, R, 1'b1));
    s = idle(); s.instr = I_ADD_RT; s.pcsrc = 2'b01;
    step(s, ex(L, FZ_NONE, FL_BR, 2'b00, 2'b00, L, 1'b0));
    s = idle(); s.instr = I_ADD_RT;
    step(s, ex(R, FZ_NONE, FL_NONE, 2'b00, 2'b00, R, 1'b0));

    // No stall: load dest is only the ID instr's destination; load to $0.
    step(lw2(I_ADDI), ex(R, FZ_NONE, FL_NONE, 2'b00, 2'b00, R, 1'b0));
    s = lw2(I_ADD_Z); s.rt = 5'd0;
    step(s, ex(R, FZ_NONE, FL_NONE, 2'b00, 2'b00, R, 1'b0));

    // Data-cache miss for three cycles, then hit.
    s = idle(); s.dren = 1'b1; s.dhit = 1'b0;
    step(s, ex(R, FZ_DW, FL_DW, 2'b00, 2'b00, R, 1'b1));
    step(s, ex(M, FZ_DW, FL_DW, 2'b00, 2'b00, M, 1'b1));
    step(s, ex(M, FZ_DW, FL_DW, 2'b00, 2'b00, M, 1'b1));
    s = idle(); s.dren = 1'b1;
    step(s, ex(M, FZ_NONE, FL_NONE, 2'b00, 2'b00, M, 1'b0));
    step(idle(), ex(R, FZ_NONE, FL_NONE, 2'b00, 2'b00, R, 1'b0));

    // Plain branch.
    s = idle(); s.pcsrc = 2'b01;
    step(s, ex(R, FZ_NONE, FL_BR, 2'b00, 2'b00, R, 1'b0));
    step(idle(), ex(R, FZ_NONE, FL_NONE, 2'b00, 2'b00, R, 1'b0));

    // Load-use interrupted by a miss resumes with its remaining bubbles.
    step(lw2(I_ADD_RS), ex(R, FZ_LU, FL_LU, 2'b00, 2'b00, R, 1'b1));
    s = idle(); s.instr = I_ADD_RS; s.dren = 1'b1; s.dhit = 1'b0;
    step(s, ex(L, FZ_DW, FL_DW, 2'b00, 2'b00, L, 1'b1));
    s.dhit = 1'b1;
    step(s, ex(M, FZ_LU, FL_LU, 2'b00, 2'b00, M, 1'b1));
    s = idle(); s.instr = I_ADD_RS;
    step(s, ex(R, FZ_NONE, FL_NONE, 2'b00, 2'b00, L, 1'b1));
    step(s, ex(R, FZ_NONE, FL_NONE, 2'b00, 2'b00, R, 1'b0));

    // Branch during a miss is deferred to the hit cycle.
    s = idle(); s.dren = 1'b1; s.dhit = 1'b0; s.pcsrc = 2'b01;
    step(s, ex(R, FZ_DW, FL_DW, 2'b00, 2'b00, R, 1'b1));
    s.dhit = 1'b1;
    step(s, ex(M, FZ_NONE, FL_BR, 2'b00, 2'b00, M, 1'b0));
    step(idle(), ex(R, FZ_NONE, FL_NONE, 2'b00, 2'b00, R, 1'b0));

    // Forwarding priority and the $0 guard.
    s = idle(); s.rs = 5'd7; s.ex_wsel = 5'd7; s.ex_wr = 1'b1; s.wb_wsel = 5'd7; s.wb_wr = 1'b1;
    step(s, ex(R, FZ_NONE, FL_NONE, 2'b10, 2'b00, R, 1'b0));
    s.ex_wr = 1'b0; s.rt = 5'd7;
    step(s, ex(R, FZ_NONE, FL_NONE, 2'b01, 2'b01, R, 1'b0));
    s = idle(); s.rt = 5'd7; s.ex_wsel = 5'd7; s.ex_wr = 1'b1; s.wb_wr = 1'b1;
    step(s, ex(R, FZ_NONE, FL_NONE, 2'b00, 2'b10, R, 1'b0));
    s = idle(); s.ex_wr = 1'b1; s.wb_wr = 1'b1;
    step(s, ex(R, FZ_NONE, FL_NONE, 2'b00, 2'b00, R, 1'b0));

    // Halt is sticky and freezes everything.
    s = idle(); s.halt = 1'b1; s.rs = 5'd7; s.ex_wsel = 5'd7; s.ex_wr = 1'b1;
    step(s, ex(R, FZ_NONE, FL_NONE, 2'b10, 2'b00, R, 1'b0));
    s.halt = 1'b0; s.pcsrc = 2'b01; s.dren = 1'b1; s.dhit = 1'b0;
    step(s, ex(H, FZ_H, FL_NONE, 2'b00, 2'b00, H, 1'b1));
    s = idle(); s.ihit = 1'b0;
    step(s, ex(H, FZ_H, FL_NONE, 2'b00, 2'b00, H, 1'b1));

    // Reset leaves halt; a reset pulse mid-stall returns to RUN.
    s = lw2(I_ADD_RS); s.rst = 1'b0;
    step(s, ex(R, FZ_NONE, FL_NONE, 2'b00, 2'b00, R, 1'b0));
    step(lw2(I_ADD_RS), ex(R, FZ_LU, FL_LU, 2'b00, 2'b00, R, 1'b1));
    s = idle(); s.instr = I_ADD_RS;
    step(s, ex(L, FZ_LU, FL_LU, 2'b00, 2'b00, L, 1'b1));
    s.rst = 1'b0;
    step(s, ex(R, FZ_NONE, FL_NONE, 2'b00, 2'b00, R, 1'b0));
    step(idle(), ex(R, FZ_NONE, FL_NONE, 2'b00, 2'b00, R, 1'b0));

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge CLK);
    @(posedge CLK);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
